// File: rtl/tmds_channel_rx_if.sv
// Bundle between the TMDS deserializer, one receive channel and the capture logic.
// err_cnt only exists when TMDS_RX_ERRCNT_EN is defined.
interface tmds_channel_rx_if;
  logic [9:0] din;
  logic       locked;
  logic [3:0] offset;
  logic       slip;
  logic       de;
  logic [7:0] dout;
  logic [1:0] ctrl;
`ifdef TMDS_RX_ERRCNT_EN
  logic [15:0] err_cnt;

  modport master (input din, output locked, offset, slip, de, dout, ctrl, err_cnt);
  modport slave  (output din, input locked, offset, slip, de, dout, ctrl, err_cnt);
`else
  modport master (input din, output locked, offset, slip, de, dout, ctrl);
  modport slave  (output din, input locked, offset, slip, de, dout, ctrl);
`endif
endinterface

// File: rtl/tmds_channel_rx.sv
// TMDS receive channel: control-token word alignment plus 10b->8b / control decode.
// Define TMDS_RX_ERRCNT_EN to add the err_cnt lock-loss / DC-balance error counter.
module tmds_channel_rx #(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_WINDOW    = 4096
) (
  input  logic              sys_clock,
  input  logic              sys_nrst,
  tmds_channel_rx_if.master bus
);

  localparam int RUN_W  = ($clog2(CTRL_RUN) > 0)       ? $clog2(CTRL_RUN)       : 1;
  localparam int TMO_W  = ($clog2(SEARCH_TIMEOUT) > 0) ? $clog2(SEARCH_TIMEOUT) : 1;
  localparam int LOSS_W = ($clog2(LOSS_WINDOW) > 0)    ? $clog2(LOSS_WINDOW)    : 1;

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t            state;
  logic [9:0]        din_q;
  logic [9:0]        sym;
  logic [3:0]        offset_q;
  logic              locked_q;
  logic              slip_q;
  logic              de_q;
  logic [7:0]        dout_q;
  logic [1:0]        ctrl_q;
  logic [RUN_W-1:0]  run;
  logic [TMO_W-1:0]  tmo;
  logic [LOSS_W-1:0] loss;

  // Two consecutive words form a 20-bit stream slice; bit 0 of din_q is the oldest bit.
  logic [19:0] pair;
  logic [9:0]  win;
  assign pair = {bus.din, din_q};
  assign win  = 10'(pair >> offset_q);

  logic       sym_tok;
  logic [1:0] sym_code;
  logic [7:0] t;
  logic [7:0] x;
  logic [7:0] sym_data;
  logic       run_done;
  logic       tmo_done;
  logic       loss_done;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sym_tok  = 1'b1;
    sym_code = 2'b00;
    case (sym)
      10'b1101010100: sym_code = 2'b00;
      10'b0010101011: sym_code = 2'b01;
      10'b0101010100: sym_code = 2'b10;
      10'b1010101011: sym_code = 2'b11;
      default:        sym_tok  = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  assign t        = sym[9] ? ~sym[7:0] : sym[7:0];
  assign x        = t ^ {t[6:0], 1'b0};
  assign sym_data = sym[8] ? {x[7:1], t[0]} : {~x[7:1], t[0]};

  assign run_done  = sym_tok && (run == RUN_W'(CTRL_RUN - 1));
  assign tmo_done  = (tmo == TMO_W'(SEARCH_TIMEOUT - 1));
  assign loss_done = (state == LOCKED) && !sym_tok && (loss == LOSS_W'(LOSS_WINDOW - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every register in
  // this block samples the pre-edge value of every other one.
  always_ff @(posedge sys_clock or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state    <= SEARCH;
      din_q    <= '0;
      sym      <= '0;
      offset_q <= '0;
      locked_q <= 1'b0;
      slip_q   <= 1'b0;
      de_q     <= 1'b0;
      dout_q   <= '0;
      ctrl_q   <= '0;
      run      <= '0;
      tmo      <= '0;
      loss     <= '0;
    end else begin
      din_q  <= bus.din;
      sym    <= win;
      slip_q <= 1'b0;

      if (sym_tok) begin
        de_q   <= 1'b0;
        dout_q <= '0;
        ctrl_q <= sym_code;
      end else begin
        de_q   <= 1'b1;
        dout_q <= sym_data;
      end

      case (state)
        SEARCH: begin
          if (run_done) begin
            state    <= LOCKED;
            locked_q <= 1'b1;
            run      <= '0;
            tmo      <= '0;
            loss     <= '0;
          end else if (tmo_done) begin
            offset_q <= (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
            slip_q   <= 1'b1;
            run      <= '0;
            tmo      <= '0;
          end else begin
            run <= sym_tok ? run + RUN_W'(1) : '0;
            tmo <= tmo + TMO_W'(1);
          end
        end
        LOCKED: begin
          if (sym_tok) begin
            loss <= '0;
          end else if (loss_done) begin
            // Drop back to hunting but retry the offset that just worked first.
            state    <= SEARCH;
            locked_q <= 1'b0;
            run      <= '0;
            tmo      <= '0;
            loss     <= '0;
          end else begin
            loss <= loss + LOSS_W'(1);
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  assign bus.locked = locked_q;
  assign bus.offset = offset_q;
  assign bus.slip   = slip_q;
  assign bus.de     = de_q;
  assign bus.dout   = dout_q;
  assign bus.ctrl   = ctrl_q;

`ifdef TMDS_RX_ERRCNT_EN
  logic [15:0] err_cnt;
  logic        bad_dc;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  assign bad_dc  = (state == LOCKED) && !sym_tok &&
                   (($countones(sym) < 4) || ($countones(sym) > 6));
  assign err_inc = {1'b0, bad_dc} + {1'b0, loss_done};
  assign err_sum = {1'b0, err_cnt} + {15'd0, err_inc};

  always_ff @(posedge sys_clock or negedge sys_nrst) begin
    if (!sys_nrst) begin
      err_cnt <= '0;
    end else begin
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign bus.err_cnt = err_cnt;
`endif

endmodule

// File: tb/tb_tmds_channel_rx.sv
// Randomized self-checking bench for tmds_channel_rx against a bit-stream level model.
// Define TMDS_RX_ERRCNT_EN to also exercise the err_cnt counter.
module tb_tmds_channel_rx;

  localparam int CTRL_RUN       = 4;
  localparam int SEARCH_TIMEOUT = 16;
  localparam int LOSS_WINDOW    = 32;
  localparam logic [9:0] T0     = 10'b1101010100;

  logic sys_clock = 1'b0;
  logic sys_nrst  = 1'b0;
  int   n_tests   = 0;
  int   n_fail    = 0;

  tmds_channel_rx_if bus ();

  tmds_channel_rx #(
    .CTRL_RUN      (CTRL_RUN),
    .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
    .LOSS_WINDOW   (LOSS_WINDOW)
  ) dut (
    .sys_clock(sys_clock),
    .sys_nrst (sys_nrst),
    .bus      (bus)
  );

  always #5 sys_clock = ~sys_clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (serial-stream view) ----------------
  logic [9:0] tokens [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  logic [9:0] m_din_q, m_sym;
  int         m_offset, m_run, m_tmo, m_loss, m_err;
  bit         m_locked, m_slip, m_de;
  logic [7:0] m_dout;
  logic [1:0] m_ctrl;
  int         enc_disp;

  function automatic int token_code(input logic [9:0] s);
    for (int i = 0; i < 4; i++) if (s == tokens[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] s);
    logic [7:0] tt, r;
    tt   = s[9] ? ~s[7:0] : s[7:0];
    r[0] = tt[0];
    for (int i = 1; i < 8; i++) r[i] = s[8] ? (tt[i] ^ tt[i-1]) : ~(tt[i] ^ tt[i-1]);
    return r;
  endfunction

  task automatic model_reset();
    m_din_q = '0; m_sym = '0; m_offset = 0; m_run = 0; m_tmo = 0; m_loss = 0;
    m_err = 0; m_locked = 0; m_slip = 0; m_de = 0; m_dout = '0; m_ctrl = '0;
  endtask

  task automatic model_step(input logic [9:0] d);
    logic [9:0] nsym;
    int tk, pop, idx;
    bit tok;
    for (int k = 0; k < 10; k++) begin
      idx     = k + m_offset;
      nsym[k] = (idx < 10) ? m_din_q[idx] : d[idx-10];
    end
    tk  = token_code(m_sym);
    tok = (tk >= 0);
    pop = $countones(m_sym);
    if (tok) begin
      m_de = 0; m_dout = '0; m_ctrl = tk[1:0];
    end else begin
      m_de = 1; m_dout = ref_decode(m_sym);
    end
    m_slip = 0;
    if (!m_locked) begin
      if (tok && m_run + 1 == CTRL_RUN) begin
        m_locked = 1; m_run = 0; m_tmo = 0; m_loss = 0;
      end else if (m_tmo == SEARCH_TIMEOUT - 1) begin
        m_offset = (m_offset + 1) % 10; m_slip = 1; m_run = 0; m_tmo = 0;
      end else begin
        m_run = tok ? m_run + 1 : 0;
        m_tmo++;
      end
    end else begin
      if (!tok && (pop < 4 || pop > 6)) m_err++;
      if (tok) m_loss = 0;
      else if (m_loss == LOSS_WINDOW - 1) begin
        m_locked = 0; m_run = 0; m_tmo = 0; m_loss = 0; m_err++;
      end else m_loss++;
    end
    if (m_err > 65535) m_err = 65535;
    m_din_q = d;
    m_sym   = nsym;
  endtask

  // DVI-style encoder with running disparity, used to build legal data symbols.
  task automatic tmds_enc(input logic [7:0] d, output logic [9:0] q);
    logic [8:0] qm;
    int n1d, n1q, n0q;
    n1d   = $countones(d);
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_disp == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      enc_disp += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((enc_disp > 0 && n1q > n0q) || (enc_disp < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_disp += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_disp += -2 * int'(!qm[8]) + n1q - n0q;
    end
  endtask

  function automatic logic [9:0] rand_data_word();
    logic [9:0] w;
    int pop;
    do begin
      w   = 10'($urandom);
      pop = $countones(w);
    end while (token_code(w) >= 0 || pop < 4 || pop > 6);
    return w;
  endfunction

  // ---------------- cycle driver ----------------
  int slips;

  task automatic compare_all();
    check("locked", 32'(bus.locked), 32'(m_locked));
    check("offset", 32'(bus.offset), 32'(m_offset));
    check("slip",   32'(bus.slip),   32'(m_slip));
    check("de",     32'(bus.de),     32'(m_de));
    check("dout",   32'(bus.dout),   32'(m_dout));
    check("ctrl",   32'(bus.ctrl),   32'(m_ctrl));
`ifdef TMDS_RX_ERRCNT_EN
    check("err_cnt", 32'(bus.err_cnt), 32'(m_err));
`endif
  endtask

  task automatic cycle(input logic [9:0] d);
    bus.din = d;
    @(posedge sys_clock);
    if (sys_nrst) model_step(d);
    else model_reset();
    @(negedge sys_clock);
    compare_all();
    if (bus.slip) slips++;
  endtask

  task automatic do_reset();
    sys_nrst = 1'b0;
    bus.din  = '0;
    model_reset();
    repeat (2) cycle(10'd0);
    sys_nrst = 1'b1;
    slips    = 0;
  endtask

  task automatic run_loss(output int first_low);
    first_low = -1;
    for (int j = 0; j < 40; j++) begin
      cycle(rand_data_word());
      if (!bus.locked && first_low < 0) first_low = j;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [9:0] w, r3, r5;
  logic [7:0] bytes_in [20];
  bit         got_de   [24];
  logic [7:0] got_dout [24];
  int         first_lock, first_low, last_slip, bad_lock;

  initial begin
    bus.din  = '0;
    enc_disp = 0;
    model_reset();
    @(negedge sys_clock);

    // Reset state
    do_reset();
    check("rst_locked", 32'(bus.locked), 0);
    check("rst_offset", 32'(bus.offset), 0);
    check("rst_dout",   32'(bus.dout),   0);

    // Aligned token stream
    first_lock = -1;
    for (int i = 1; i <= 7; i++) begin
      cycle(T0);
      if (bus.locked && first_lock < 0) first_lock = i;
    end
    check("lock_aligned",  32'(bus.locked), 1);
    check("lock_within_7", 32'(first_lock > 0 && first_lock <= 7), 1);
    check("lock_offset0",  32'(bus.offset), 0);
    check("no_slip",       32'(slips), 0);
    check("tok_ctrl",      32'(bus.ctrl), 0);
    check("tok_de",        32'(bus.de), 0);

    // Encoded data: fixed corner bytes then random bytes
    bytes_in[0] = 8'h00; bytes_in[1] = 8'h55; bytes_in[2] = 8'hA5; bytes_in[3] = 8'hFF;
    for (int i = 4; i < 20; i++) bytes_in[i] = 8'($urandom);
    for (int i = 0; i < 22; i++) begin
      if (i < 20) tmds_enc(bytes_in[i], w);
      else w = T0;
      cycle(w);
      got_de[i]   = bus.de;
      got_dout[i] = bus.dout;
    end
    for (int i = 0; i < 20; i++) begin
      check($sformatf("data_de_%0d", i),   32'(got_de[i+2]),   1);
      check($sformatf("data_dout_%0d", i), 32'(got_dout[i+2]), 32'(bytes_in[i]));
    end
    repeat (4) cycle(T0);
    check("data_still_locked", 32'(bus.locked), 1);

    // Loss of lock and relock at the same offset
    slips = 0;
    run_loss(first_low);
    check("loss_drop_cycle", 32'(first_low), 33);
    check("loss_offset",     32'(bus.offset), 0);
    repeat (12) cycle(T0);
    check("relock",          32'(bus.locked), 1);
    check("relock_offset",   32'(bus.offset), 0);
    check("relock_no_slip",  32'(slips), 0);

    // Stream pre-rotated by 3 bits
    r3 = {T0[6:0], T0[9:7]};
    do_reset();
    last_slip = -1;
    bad_lock  = 0;
    for (int i = 0; i < 80; i++) begin
      cycle(r3);
      if (bus.slip) begin
        if (last_slip >= 0) check("slip_spacing", 32'(i - last_slip), 16);
        last_slip = i;
      end
      if (bus.locked && bus.offset != 4'd3) bad_lock++;
    end
    check("rot3_slips",      32'(slips), 3);
    check("rot3_locked",     32'(bus.locked), 1);
    check("rot3_offset",     32'(bus.offset), 3);
    check("rot3_no_early",   32'(bad_lock), 0);

    // Lock at offset 5, then reset mid-stream
    r5 = {T0[4:0], T0[9:5]};
    do_reset();
    repeat (100) cycle(r5);
    check("rot5_locked", 32'(bus.locked), 1);
    check("rot5_offset", 32'(bus.offset), 5);
    #2 sys_nrst = 1'b0;
    #1;
    model_reset();
    check("mid_rst_locked", 32'(bus.locked), 0);
    check("mid_rst_offset", 32'(bus.offset), 0);
    check("mid_rst_de",     32'(bus.de),     0);
    check("mid_rst_ctrl",   32'(bus.ctrl),   0);
    repeat (3) cycle(r5);
    sys_nrst = 1'b1;
    slips    = 0;
    repeat (5) cycle(r5);
    check("post_rst_offset", 32'(bus.offset), 0);
    check("post_rst_search", 32'(bus.locked), 0);
    repeat (60) cycle(r5);

`ifdef TMDS_RX_ERRCNT_EN
    do_reset();
    repeat (10) cycle(T0);
    for (int k = 0; k < 2; k++) begin
      run_loss(first_low);
      repeat (12) cycle(T0);
    end
    check("err_two_losses", 32'(bus.err_cnt), 2);
    cycle(10'b1111111111);
    repeat (4) cycle(T0);
    check("err_bad_dc",     32'(bus.err_cnt), 3);
    check("err_keeps_lock", 32'(bus.locked), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
